// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter with a bounded hold time.
// A requester keeps its grant while it keeps requesting, but once it has held
// for MAX_HOLD cycles it must yield to any other requester. The search for the
// next winner starts just below the last granted index and wraps downward.
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] grant_id,
  output logic       grant_valid
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [3:0] hold_cnt_q, hold_cnt_d;
  logic [7:0] grant_q, grant_d;
  logic       grant_valid_q, grant_valid_d;

  // Requests seen by the search. When the holder is still requesting, the
  // only reason to search is to hand over, so the holder is masked out.
  logic       excl_holder;
  logic [7:0] search_req;
  logic [2:0] cand_idx [8];
  logic [7:0] cand_hit;
  logic       found;
  logic [2:0] win_idx;

  assign excl_holder = (state_q == BUSY) && req[ptr_q];
  assign search_req  = excl_holder ? (req & ~(8'd1 << ptr_q)) : req;

  // Candidate gi is the (gi+1)-th index below ptr, modulo 8; position 0 is
  // searched first and position 7 (ptr itself) last.
  for (genvar gi = 0; gi < 8; gi++) begin : g_cand
    assign cand_idx[gi] = ptr_q - 3'(gi + 1);
    assign cand_hit[gi] = search_req[cand_idx[gi]];
  end

  // Priority pick: the lowest search position that has a request wins.
  always_comb begin
    found   = 1'b0;
    win_idx = ptr_q;
    for (int i = 7; i >= 0; i--) begin
      if (cand_hit[i]) begin
        found   = 1'b1;
        win_idx = cand_idx[i];
      end
    end
  end

  // State register: reset clears everything at once, without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= 3'd0;
      hold_cnt_q    <= 4'd0;
      grant_q       <= 8'd0;
      grant_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      hold_cnt_q    <= hold_cnt_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
    end
  end

  // Next-state logic: decide keep / hand over / new grant / drop to idle.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    hold_cnt_d    = hold_cnt_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d       = BUSY;
          ptr_d         = win_idx;
          hold_cnt_d    = 4'd1;
          grant_d       = 8'd1 << win_idx;
          grant_valid_d = 1'b1;
        end
      end
      BUSY: begin
        if (req[ptr_q] && (hold_cnt_q < MAX_HOLD_C)) begin
          hold_cnt_d = hold_cnt_q + 4'd1;
        end else if (found) begin
          // Either the holder has used up its hold budget and someone else
          // is waiting, or the holder released and another takes over with
          // no idle bubble.
          ptr_d         = win_idx;
          hold_cnt_d    = 4'd1;
          grant_d       = 8'd1 << win_idx;
          grant_valid_d = 1'b1;
        end else if (!req[ptr_q]) begin
          state_d       = IDLE;
          grant_d       = 8'd0;
          grant_valid_d = 1'b0;
        end
        // Otherwise the holder is alone at the limit: keep it, count saturated.
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs come straight from flops; ptr always equals the last granted
  // index, so it doubles as grant_id and holds through idle periods.
  always_comb begin
    grant       = grant_q;
    grant_id    = ptr_q;
    grant_valid = grant_valid_q;
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Testbench for rr_arbiter8: directed vector table, hand-written corner
// sequences, and random traffic compared against a behavioural model.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_id;
  logic       grant_valid;

  rr_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .grant      (grant),
    .grant_id   (grant_id),
    .grant_valid(grant_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state: current owner (-1 = none), cycles held, last granted.
  int m_owner;
  int m_held;
  int m_last;

  typedef struct {
    logic [7:0] req;
    logic [7:0] exp_grant;
    logic [2:0] exp_id;
    logic       exp_valid;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // First requester found walking downward from just below 'last', skipping 'excl'.
  function automatic int pick(input logic [7:0] r, input int last, input int excl);
    int order[$];
    for (int d = 1; d <= 8; d++) order.push_back((last + 8 - d) % 8);
    foreach (order[j]) if (r[order[j]] && order[j] != excl) return order[j];
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_last  = 0;
  endtask

  task automatic model_step(input logic [7:0] r);
    int w;
    if (m_owner < 0) w = pick(r, m_last, -1);
    else if (r[m_owner] && m_held < 4) begin
      m_held++;
      return;
    end else if (r[m_owner]) w = pick(r, m_last, m_owner);
    else w = pick(r, m_last, -1);
    if (w >= 0) begin
      m_owner = w;
      m_held  = 1;
      m_last  = w;
    end else if (m_owner >= 0 && !r[m_owner]) begin
      m_owner = -1;
    end
  endtask

  // Apply one request vector across one rising edge; return at the next falling edge.
  task automatic cycle(input logic [7:0] r);
    req = r;
    @(posedge clk);
    model_step(r);
    @(negedge clk);
  endtask

  task automatic check_model(input string tag, input logic [7:0] r);
    logic [7:0] eg;
    eg = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
    chk({tag, ".grant"}, 32'(grant), 32'(eg));
    chk({tag, ".id"}, 32'(grant_id), 32'(m_last));
    chk({tag, ".valid"}, 32'(grant_valid), 32'(m_owner >= 0));
    chk({tag, ".onehot0"}, 32'($countones(grant) <= 1), 32'd1);
    chk({tag, ".granted_req"}, 32'(grant & ~r), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 8'd0;
    #1;
    chk("reset.grant", 32'(grant), 32'd0);
    chk("reset.id", 32'(grant_id), 32'd0);
    chk("reset.valid", 32'(grant_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] prev;
    int         eid;

    // Directed per-cycle vectors, applied right after a reset.
    tbl[0]  = '{8'h81, 8'h80, 3'd7, 1'b1};  // first search starts at 7
    tbl[1]  = '{8'h81, 8'h80, 3'd7, 1'b1};
    tbl[2]  = '{8'h81, 8'h80, 3'd7, 1'b1};
    tbl[3]  = '{8'h81, 8'h80, 3'd7, 1'b1};
    tbl[4]  = '{8'h81, 8'h01, 3'd0, 1'b1};  // hold budget of 4 used up
    tbl[5]  = '{8'h00, 8'h00, 3'd0, 1'b0};
    tbl[6]  = '{8'h02, 8'h02, 3'd1, 1'b1};
    tbl[7]  = '{8'h00, 8'h00, 3'd1, 1'b0};  // idle keeps last id
    tbl[8]  = '{8'h00, 8'h00, 3'd1, 1'b0};
    tbl[9]  = '{8'h20, 8'h20, 3'd5, 1'b1};  // search 0,7,6,5
    tbl[10] = '{8'h48, 8'h08, 3'd3, 1'b1};  // release, search 4,3 with no bubble
    tbl[11] = '{8'h48, 8'h08, 3'd3, 1'b1};

    rst = 1'b1;
    req = 8'd0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].req);
      chk($sformatf("vec%0d.grant", i), 32'(grant), 32'(tbl[i].exp_grant));
      chk($sformatf("vec%0d.id", i), 32'(grant_id), 32'(tbl[i].exp_id));
      chk($sformatf("vec%0d.valid", i), 32'(grant_valid), 32'(tbl[i].exp_valid));
    end

    // Lone requester keeps its grant indefinitely with the counter saturated.
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      cycle(8'h10);
      chk($sformatf("solo%0d.grant", c), 32'(grant), 32'h10);
      chk($sformatf("solo%0d.hold", c), 32'(dut.hold_cnt_q), 32'((c < 4) ? c : 4));
    end

    // Everyone requesting: strict rotation 7..0, four cycles each.
    do_reset();
    for (int c = 1; c <= 36; c++) begin
      cycle(8'hFF);
      eid = 7 - (((c - 1) / 4) % 8);
      chk($sformatf("all%0d.grant", c), 32'(grant), 32'(8'd1 << eid));
    end

    // Asynchronous reset in the middle of a grant, then restart.
    do_reset();
    cycle(8'h04);
    chk("arst.pre", 32'(grant), 32'h04);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.grant", 32'(grant), 32'd0);
    chk("arst.valid", 32'(grant_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cycle(8'h04);
    chk("arst.after.grant", 32'(grant), 32'h04);
    chk("arst.after.id", 32'(grant_id), 32'd2);

    // Random traffic with occasional repeats so holds reach their limit.
    do_reset();
    prev = 8'd0;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 5))
        0, 1:    r = prev;
        2:       r = 8'd0;
        3:       r = 8'(1 << $urandom_range(0, 7));
        default: r = 8'($urandom);
      endcase
      prev = r;
      cycle(r);
      check_model($sformatf("rnd%0d", n), r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
